// File: rtl/serial_tx_pkg.sv
// Shared definitions for the serial frame transmitter: state encoding and
// frame/counter constants.
package serial_tx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } tx_state_e;

   localparam int         FRAME_BITS = 16;
   localparam logic [3:0] CNT_LAST   = 4'd15;

endpackage

// File: rtl/serial_tx_fsm_if.sv
// Handshake/data bundle between the transmitter and its environment
// (requester plus the external 4-bit bit-index counter).
interface serial_tx_fsm_if
   import serial_tx_pkg::*;
   ();

   logic                  start;
   logic [FRAME_BITS-1:0] data_in;
   logic                  pause;
   logic [3:0]            cnt_q;
   logic                  count16_init;
   logic                  count16_inc;
   logic                  sdata;
   logic                  busy;
   logic                  done;
   logic                  err;

   modport slave (
      input  start, data_in, pause, cnt_q,
      output count16_init, count16_inc, sdata, busy, done, err
   );

   modport master (
      output start, data_in, pause, cnt_q,
      input  count16_init, count16_inc, sdata, busy, done, err
   );

endinterface

// File: rtl/serial_tx_fsm_shift16.sv
// 16-bit load/shift/hold register; shifts left with zero fill, load wins
// over shift.
module shift16
   import serial_tx_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic                  shift,
   input  logic [FRAME_BITS-1:0] d,
   output logic [FRAME_BITS-1:0] q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else if (load) begin
         q <= d;
      end else if (shift) begin
         q <= {q[FRAME_BITS-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/serial_tx_fsm.sv
// Serial frame transmitter: sends a 16-bit word MSB first, paced by an
// external 4-bit counter that it clears and increments.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | waiting for start; counter held cleared
//   ST_SHIFT | one bit per unpaused cycle, counter incremented per bit
//   ST_DONE  | single-cycle completion pulse; counter cleared again
module serial_tx_fsm
   import serial_tx_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   serial_tx_fsm_if.slave  bus
);

   tx_state_e             state;
   tx_state_e             state_nxt;
   logic [FRAME_BITS-1:0] shreg;
   logic                  load;
   logic                  shift;
   logic                  first_q;
   logic                  err_q;

   assign load  = (state == ST_IDLE)  && bus.start;
   assign shift = (state == ST_SHIFT) && !bus.pause;

   shift16 u_shift16 (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load),
      .shift (shift),
      .d     (bus.data_in),
      .q     (shreg)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (bus.start) state_nxt = ST_SHIFT;
         ST_SHIFT: if (!bus.pause && (bus.cnt_q == CNT_LAST)) state_nxt = ST_DONE;
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // first_q marks the opening SHIFT cycle, where the counter must read zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         first_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         if (load) begin
            first_q <= 1'b1;
         end else if (state == ST_SHIFT) begin
            first_q <= 1'b0;
         end
         if ((state == ST_SHIFT) && first_q && (bus.cnt_q != 4'd0)) begin
            err_q <= 1'b1;
         end
      end
   end

   always_comb begin
      bus.count16_init = 1'b0;
      bus.count16_inc  = 1'b0;
      bus.sdata        = 1'b0;
      bus.busy         = 1'b0;
      bus.done         = 1'b0;
      bus.err          = err_q;
      case (state)
         ST_IDLE: begin
            bus.count16_init = 1'b1;
         end
         ST_SHIFT: begin
            bus.count16_inc = !bus.pause;
            bus.sdata       = shreg[FRAME_BITS-1];
            bus.busy        = 1'b1;
         end
         ST_DONE: begin
            bus.count16_init = 1'b1;
            bus.busy         = 1'b1;
            bus.done         = 1'b1;
         end
         default: begin
            bus.count16_init = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_serial_tx_fsm.sv
// Bench for serial_tx_fsm: behavioural counter plus frame-level reference
// (bits MSB first, one per unpaused cycle) with directed and random frames.
module tb_serial_tx_fsm;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   logic       force_en;
   logic [3:0] force_val;
   logic [3:0] cnt_model;
   logic       err_exp;

   serial_tx_fsm_if bus ();

   serial_tx_fsm dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Downstream 4-bit counter: synchronous clear over increment.
   initial cnt_model = 4'd0;
   always @(posedge clk) begin
      if (bus.count16_init)     cnt_model <= 4'd0;
      else if (bus.count16_inc) cnt_model <= cnt_model + 4'd1;
   end
   assign bus.cnt_q = force_en ? force_val : cnt_model;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         checks++;
         assert (!(bus.count16_init && bus.count16_inc)) else begin
            errors++;
            $error("FAIL init_inc_excl: observed init=%0b inc=%0b expected not both",
                   bus.count16_init, bus.count16_inc);
         end
      end
   end

   task automatic chk_idle(input string tag);
      chk({tag, "_busy"}, bus.busy, 0);
      chk({tag, "_done"}, bus.done, 0);
      chk({tag, "_sdata"}, bus.sdata, 0);
      chk({tag, "_init"}, bus.count16_init, 1);
      chk({tag, "_inc"}, bus.count16_inc, 0);
      chk({tag, "_err"}, bus.err, err_exp);
   endtask

   // Precondition: in IDLE, just after a rising edge. Leaves in IDLE likewise.
   task automatic run_frame(input logic [15:0] d, input int pause_at, input int pause_len,
                            input bit rnd_pause, input bit hold_start, input bit force_first);
      int idx, cyc, npause, plen_left, obs_shift, obs_inc;
      idx = 0; cyc = 0; npause = 0; plen_left = pause_len; obs_shift = 0; obs_inc = 0;
      chk_idle("idle");
      bus.start   = 1'b1;
      bus.data_in = d;
      @(posedge clk); #1;
      while (idx < 16 && cyc < 80) begin
         if (idx == pause_at && plen_left > 0) begin
            bus.pause = 1'b1;
            plen_left--;
         end else begin
            bus.pause = rnd_pause && idx > 0 && ($urandom_range(0, 3) == 0);
         end
         if (!hold_start) bus.start = 1'($urandom_range(0, 1));
         bus.data_in = 16'($urandom);
         if (force_first && cyc == 0) begin
            force_en  = 1'b1;
            force_val = 4'd3;
         end
         #1;
         chk("shift_sdata", bus.sdata, d[15-idx]);
         chk("shift_busy", bus.busy, 1);
         chk("shift_done", bus.done, 0);
         chk("shift_init", bus.count16_init, 0);
         chk("shift_inc", bus.count16_inc, !bus.pause);
         chk("shift_err", bus.err, err_exp);
         obs_shift += (bus.busy && !bus.done) ? 1 : 0;
         obs_inc   += bus.count16_inc ? 1 : 0;
         if (bus.pause) npause++;
         else idx++;
         cyc++;
         @(posedge clk); #1;
         force_en = 1'b0;
         if (force_first && cyc == 1) err_exp = 1'b1;
      end
      chk("frame_bound", (cyc < 80) ? 1 : 0, 1);
      bus.pause = 1'b0;
      if (!hold_start) bus.start = 1'b0;
      #1;
      chk("done_pulse", bus.done, 1);
      chk("done_busy", bus.busy, 1);
      chk("done_init", bus.count16_init, 1);
      chk("done_inc", bus.count16_inc, 0);
      chk("done_sdata", bus.sdata, 0);
      chk("shift_cycles", obs_shift, 16 + npause);
      chk("inc_count", obs_inc, 16);
      @(posedge clk); #1;
      chk("after_done", bus.done, 0);
      chk("after_busy", bus.busy, 0);
   endtask

   initial begin
      checks = 0; errors = 0;
      force_en = 1'b0; force_val = 4'd0; err_exp = 1'b0;
      bus.start = 1'b0; bus.data_in = 16'h0; bus.pause = 1'b0;
      rst_n = 1'b0;
      #1;
      chk_idle("reset");
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      run_frame(16'hA5C3, -1, 0, 1'b0, 1'b0, 1'b0);
      run_frame(16'hFFFF, 8, 3, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++)
         run_frame(16'($urandom), -1, 0, 1'b1, 1'b0, 1'b0);

      // back-to-back with start held high throughout
      run_frame(16'($urandom), -1, 0, 1'b0, 1'b1, 1'b0);
      run_frame(16'($urandom), -1, 0, 1'b1, 1'b1, 1'b0);
      run_frame(16'($urandom), -1, 0, 1'b0, 1'b0, 1'b0);

      // misaligned counter at frame start makes err sticky
      run_frame(16'($urandom), -1, 0, 1'b0, 1'b0, 1'b1);
      run_frame(16'($urandom), -1, 0, 1'b1, 1'b0, 1'b0);

      // reset at bit 7 of 16'h1234
      bus.start = 1'b1; bus.data_in = 16'h1234;
      @(posedge clk); #1;
      bus.start = 1'b0;
      for (int i = 0; i < 7; i++) begin
         chk("rst_pre_sdata", bus.sdata, 16'h1234 >> (15 - i) & 1);
         @(posedge clk); #1;
      end
      chk("rst_bit7_busy", bus.busy, 1);
      #1;
      rst_n = 1'b0;
      #1;
      err_exp = 1'b0;
      chk_idle("rst_async");
      @(posedge clk); @(posedge clk); #1;
      chk("rst_hold_done", bus.done, 0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_cnt_cleared", bus.cnt_q, 0);
      chk("rst_no_done", bus.done, 0);
      run_frame(16'h1234, -1, 0, 1'b0, 1'b0, 1'b0);
      run_frame(16'($urandom), -1, 0, 1'b1, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed no finish expected finish before 200000");
      $fatal(1, "timeout");
   end

endmodule
